// File: rtl/conv_encoder_ctrl_pkg.sv
// Shared definitions for the convolutional-encoder frame sequencer.
// Holds frame/code geometry, code-rate encodings, the controller state
// type and the helper that shapes a captured coded frame.
package conv_encoder_ctrl_pkg;

  // Frame and code geometry
  localparam int FRAME_BITS   = 128;                 // message bits per encoder run
  localparam int CODED_BITS   = 384;                 // widest coded frame (rate 1/3)
  localparam int STATE_REGS   = 8;                   // encoder shift-register width
  localparam int K_LEN        = 9;                   // generator polynomial width
  localparam int N_POLY       = 3;                   // number of generator polynomials
  localparam int DONE_TIMEOUT = 4;                   // cycles after last bit to wait for done
  localparam int CNT_W        = $clog2(FRAME_BITS);  // bit counter width (7)
  localparam int TMO_W        = 3;                   // done-timeout counter width

  // Code-rate select encodings
  localparam logic CODE_RATE_2 = 1'b0;
  localparam logic CODE_RATE_3 = 1'b1;

  // One K_LEN-bit polynomial per code output
  typedef logic [N_POLY-1:0][K_LEN-1:0] gen_poly_t;

  // Controller sequencing states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLEAR     = 3'd1,
    WARM      = 3'd2,
    RUN       = 3'd3,
    WAIT_DONE = 3'd4,
    OUT       = 3'd5
  } ctrl_state_e;

  // Shape the encoder output for capture: at rate 1/2 only the upper
  // 256 bits carry symbols, so the low 128 bits are forced to zero no
  // matter what the encoder left there.
  function automatic logic [CODED_BITS-1:0] coded_capture(
    input logic [CODED_BITS-1:0] enc_data,
    input logic                  code_rate
  );
    logic [CODED_BITS-1:0] shaped;
    shaped = enc_data;
    case (code_rate)
      CODE_RATE_2: shaped[FRAME_BITS-1:0] = {FRAME_BITS{1'b0}};
      CODE_RATE_3: shaped = enc_data;
      default:     shaped = {CODED_BITS{1'b0}};
    endcase
    return shaped;
  endfunction

endpackage

// File: rtl/conv_encoder_ctrl_shifter.sv
// Message frame shift register for the sequencer.
// Loads a whole frame on accept and shifts left one bit per encoder
// cycle; the current MSB is the bit being presented to the encoder.
module conv_frame_shifter
  import conv_encoder_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic [FRAME_BITS-1:0] data_i,
  output logic                  msb_o
);

  logic [FRAME_BITS-1:0] frame_q;

  // Frame register: load has priority over shift, zero fill from the right
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= {FRAME_BITS{1'b0}};
    end else if (load_i) begin
      frame_q <= data_i;
    end else if (shift_i) begin
      frame_q <= {frame_q[FRAME_BITS-2:0], 1'b0};
    end
  end

  assign msb_o = frame_q[FRAME_BITS-1];

endmodule

// File: rtl/conv_encoder_ctrl.sv
// Frame sequencer for conv_encoder.
// Accepts a message frame plus code configuration, clears and seeds the
// encoder, streams the frame MSB first, waits for the encoder's done and
// hands the coded frame downstream. The encoder's end state is tracked
// locally so a following frame can continue the same code stream.
module conv_encoder_ctrl
  import conv_encoder_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  // upstream frame interface
  input  logic                  i_frm_valid,
  output logic                  o_frm_ready,
  input  logic [FRAME_BITS-1:0] i_frm_data,
  input  logic                  i_code_rate,
  input  gen_poly_t             i_gen_poly,
  input  logic                  i_chain,
  // encoder control
  output logic                  o_enc_rst_n,
  output logic                  o_enc_en,
  output logic                  o_enc_tx_data,
  output logic [STATE_REGS-1:0] o_enc_prv_state,
  output gen_poly_t             o_enc_gen_poly,
  output logic                  o_enc_code_rate,
  input  logic                  i_enc_done,
  input  logic [CODED_BITS-1:0] i_enc_data,
  // downstream coded-frame interface
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [CODED_BITS-1:0] o_out_data,
  output logic                  o_err_timeout
);

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DONE_TIMEOUT - 1);

  ctrl_state_e           state_q,     state_d;
  logic [CNT_W-1:0]      bit_cnt_q,   bit_cnt_d;
  logic [TMO_W-1:0]      tmo_cnt_q,   tmo_cnt_d;
  logic [STATE_REGS-1:0] chain_q,     chain_d;
  logic [STATE_REGS-1:0] prv_state_q, prv_state_d;
  gen_poly_t             poly_q,      poly_d;
  logic                  rate_q,      rate_d;
  logic [CODED_BITS-1:0] out_data_q,  out_data_d;
  logic                  err_q,       err_d;

  logic frame_load;
  logic frame_shift;
  logic frame_msb;

  conv_frame_shifter u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load_i  (frame_load),
    .shift_i (frame_shift),
    .data_i  (i_frm_data),
    .msb_o   (frame_msb)
  );

  // Next-state logic and per-state encoder/handshake controls
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    chain_d       = chain_q;
    prv_state_d   = prv_state_q;
    poly_d        = poly_q;
    rate_d        = rate_q;
    out_data_d    = out_data_q;
    err_d         = err_q;
    frame_load    = 1'b0;
    frame_shift   = 1'b0;
    o_frm_ready   = 1'b0;
    o_enc_rst_n   = 1'b0;
    o_enc_en      = 1'b0;
    o_enc_tx_data = 1'b0;
    o_out_valid   = 1'b0;

    case (state_q)
      IDLE: begin
        o_frm_ready = 1'b1;
        if (i_frm_valid) begin
          // Everything the run needs is captured here; later input
          // changes cannot disturb the frame in flight.
          frame_load  = 1'b1;
          poly_d      = i_gen_poly;
          rate_d      = i_code_rate;
          prv_state_d = i_chain ? chain_q : {STATE_REGS{1'b0}};
          state_d     = CLEAR;
        end else begin
          state_d = IDLE;
        end
      end

      CLEAR: begin
        // Encoder held in reset for one cycle while it samples the seed
        bit_cnt_d = {CNT_W{1'b0}};
        state_d   = WARM;
      end

      WARM: begin
        // Primes the encoder's input slice with the first bit; no shift
        // so RUN cycle 0 presents the same bit again.
        o_enc_rst_n   = 1'b1;
        o_enc_en      = 1'b1;
        o_enc_tx_data = frame_msb;
        state_d       = RUN;
      end

      RUN: begin
        o_enc_rst_n   = 1'b1;
        o_enc_en      = 1'b1;
        o_enc_tx_data = frame_msb;
        frame_shift   = 1'b1;
        // Mirror of the encoder register: newest bit lands in the LSB
        chain_d       = {chain_q[STATE_REGS-2:0], frame_msb};
        if (bit_cnt_q == BIT_LAST) begin
          tmo_cnt_d = {TMO_W{1'b0}};
          state_d   = WAIT_DONE;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end

      WAIT_DONE: begin
        o_enc_rst_n = 1'b1;
        o_enc_en    = 1'b1;
        if (i_enc_done) begin
          out_data_d = coded_capture(i_enc_data, rate_q);
          state_d    = OUT;
        end else if (tmo_cnt_q >= TMO_LAST) begin
          // Encoder never finished: flag it and abandon the frame. The
          // tracked end state is no longer trustworthy, so forget it.
          err_d   = 1'b1;
          chain_d = {STATE_REGS{1'b0}};
          state_d = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      OUT: begin
        o_out_valid = 1'b1;
        if (i_out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = OUT;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= {CNT_W{1'b0}};
      tmo_cnt_q   <= {TMO_W{1'b0}};
      chain_q     <= {STATE_REGS{1'b0}};
      prv_state_q <= {STATE_REGS{1'b0}};
      poly_q      <= '0;
      rate_q      <= 1'b0;
      out_data_q  <= {CODED_BITS{1'b0}};
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      chain_q     <= chain_d;
      prv_state_q <= prv_state_d;
      poly_q      <= poly_d;
      rate_q      <= rate_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end

  assign o_enc_prv_state = prv_state_q;
  assign o_enc_gen_poly  = poly_q;
  assign o_enc_code_rate = rate_q;
  assign o_out_data      = out_data_q;
  assign o_err_timeout   = err_q;

endmodule

// File: tb/tb_conv_encoder_ctrl.sv
// Self-checking bench for conv_encoder_ctrl with a behavioural encoder stub.
module tb_conv_encoder_ctrl;
  import conv_encoder_ctrl_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  i_frm_valid;
  logic                  o_frm_ready;
  logic [FRAME_BITS-1:0] i_frm_data;
  logic                  i_code_rate;
  gen_poly_t             i_gen_poly;
  logic                  i_chain;
  logic                  o_enc_rst_n;
  logic                  o_enc_en;
  logic                  o_enc_tx_data;
  logic [STATE_REGS-1:0] o_enc_prv_state;
  gen_poly_t             o_enc_gen_poly;
  logic                  o_enc_code_rate;
  logic                  enc_done = 1'b0;
  logic [CODED_BITS-1:0] enc_data = '0;
  logic                  o_out_valid;
  logic                  i_out_ready;
  logic [CODED_BITS-1:0] o_out_data;
  logic                  o_err_timeout;

  int vectors     = 0;
  int miscompares = 0;

  localparam int M_NORMAL = 0;
  localparam int M_NEVER  = 1;
  localparam int M_EARLY  = 2;
  int stub_mode = M_NORMAL;

  logic [STATE_REGS-1:0] model_end = '0;  // expected encoder end state of last good frame

  always #5 clk = ~clk;

  conv_encoder_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .i_frm_valid     (i_frm_valid),
    .o_frm_ready     (o_frm_ready),
    .i_frm_data      (i_frm_data),
    .i_code_rate     (i_code_rate),
    .i_gen_poly      (i_gen_poly),
    .i_chain         (i_chain),
    .o_enc_rst_n     (o_enc_rst_n),
    .o_enc_en        (o_enc_en),
    .o_enc_tx_data   (o_enc_tx_data),
    .o_enc_prv_state (o_enc_prv_state),
    .o_enc_gen_poly  (o_enc_gen_poly),
    .o_enc_code_rate (o_enc_code_rate),
    .i_enc_done      (enc_done),
    .i_enc_data      (enc_data),
    .o_out_valid     (o_out_valid),
    .i_out_ready     (i_out_ready),
    .o_out_data      (o_out_data),
    .o_err_timeout   (o_err_timeout)
  );

  // Reference convolutional code: each message bit b forms a window
  // {state, b}; every active polynomial contributes the parity of the
  // tapped window bits. Symbols are packed MSB first from bit 767.
  function automatic logic [767:0] ref_encode(input logic [STATE_REGS-1:0] seed,
                                              input logic [255:0] msg, input int nbits,
                                              input logic rate, input gen_poly_t poly);
    logic [767:0]          r;
    logic [STATE_REGS-1:0] s;
    logic [K_LEN-1:0]      w;
    int                    pos;
    int                    np;
    r   = '0;
    s   = seed;
    pos = 767;
    np  = (rate == CODE_RATE_3) ? 3 : 2;
    for (int i = 0; i < nbits; i++) begin
      w = {s, msg[255-i]};
      for (int p = 0; p < np; p++) begin
        r[pos] = ^(w & poly[p]);
        pos--;
      end
      s = {s[STATE_REGS-2:0], msg[255-i]};
    end
    return r;
  endfunction

  // Encoder stub: seeds while held in reset, skips the first enabled
  // (slice-priming) bit, records the next 128, raises done one cycle later.
  int                    en_cnt = 0;
  logic [STATE_REGS-1:0] stub_seed = '0;
  logic [FRAME_BITS-1:0] rx_bits = '0;
  logic [767:0]          stub_full;
  always @(negedge clk) begin
    if (rst || !o_enc_rst_n) begin
      stub_seed <= o_enc_prv_state;
      en_cnt    <= 0;
      enc_done  <= 1'b0;
    end else if (o_enc_en) begin
      en_cnt   <= en_cnt + 1;
      enc_done <= 1'b0;
      if (en_cnt >= 1 && en_cnt <= FRAME_BITS) rx_bits[FRAME_BITS-en_cnt] <= o_enc_tx_data;
      if (stub_mode == M_EARLY && en_cnt == 50) begin
        enc_done <= 1'b1;
        enc_data <= {12{$urandom}};
      end
      if (stub_mode != M_NEVER && en_cnt == FRAME_BITS + 1) begin
        stub_full = ref_encode(stub_seed, {rx_bits, 128'b0}, FRAME_BITS, o_enc_code_rate, o_enc_gen_poly);
        enc_done <= 1'b1;
        if (o_enc_code_rate == CODE_RATE_2)
          enc_data <= {stub_full[767:640], stub_full[639:512], {4{$urandom}}};
        else
          enc_data <= stub_full[767:384];
      end
    end else begin
      enc_done <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [767:0] obs, input logic [767:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer a frame at a negedge, accept on the next posedge, then scramble inputs
  task automatic send(input logic [FRAME_BITS-1:0] d, input logic rate,
                      input gen_poly_t poly, input logic chain,
                      input logic [STATE_REGS-1:0] exp_seed);
    check("ready_before_accept", 768'(o_frm_ready), 768'(1));
    i_frm_valid = 1'b1;
    i_frm_data  = d;
    i_code_rate = rate;
    i_gen_poly  = poly;
    i_chain     = chain;
    @(posedge clk);
    #1;
    i_frm_valid = 1'b0;
    i_frm_data  = {4{$urandom}};
    i_code_rate = 1'($urandom);
    i_gen_poly  = gen_poly_t'($urandom);
    i_chain     = 1'($urandom);
    #1;
    check("seed_after_accept", 768'(o_enc_prv_state), 768'(exp_seed));
    check("poly_latched", 768'(o_enc_gen_poly), 768'(poly));
    check("rate_latched", 768'(o_enc_code_rate), 768'(rate));
    check("ready_low_after_accept", 768'(o_frm_ready), 768'(0));
  endtask

  // Full frame: accept, latency, coded data, optional backpressure, handshake
  task automatic run_frame(input logic [FRAME_BITS-1:0] d, input logic rate,
                           input gen_poly_t poly, input logic chain, input int hold,
                           output logic [CODED_BITS-1:0] got);
    logic [STATE_REGS-1:0] exp_seed;
    logic [767:0]          full;
    int                    n;
    exp_seed = chain ? model_end : '0;
    send(d, rate, poly, chain, exp_seed);
    n = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (o_out_valid === 1'b1) begin
        n = i;
        break;
      end
    end
    check("valid_latency_edges", 768'(n - 1), 768'(FRAME_BITS + 3));
    full = ref_encode(exp_seed, {d, 128'b0}, FRAME_BITS, rate, poly);
    check("coded_frame", 768'(o_out_data), 768'(full[767:384]));
    got = o_out_data;
    for (int h = 0; h < hold; h++) begin
      i_frm_valid = 1'b1;
      i_frm_data  = {4{$urandom}};
      @(negedge clk);
      check("hold_data_stable", 768'(o_out_data), 768'(got));
      check("hold_ready_low", 768'({o_frm_ready, o_out_valid}), 768'(2'b01));
      check("hold_seed_unchanged", 768'(o_enc_prv_state), 768'(exp_seed));
    end
    i_frm_valid = 1'b0;
    i_out_ready = 1'b1;
    @(posedge clk);
    #1;
    i_out_ready = 1'b0;
    @(negedge clk);
    check("idle_after_handshake", 768'({o_frm_ready, o_out_valid}), 768'(2'b10));
    model_end = d[STATE_REGS-1:0];
  endtask

  initial begin
    logic [CODED_BITS-1:0] o1, o2;
    logic [FRAME_BITS-1:0] f1, f2;
    logic [767:0]          cont;
    gen_poly_t             pstd;
    gen_poly_t             pr;
    logic                  rr, cr;

    pstd        = {9'o557, 9'o663, 9'o711};
    rst         = 1'b1;
    i_frm_valid = 1'b0;
    i_frm_data  = '0;
    i_code_rate = 1'b0;
    i_gen_poly  = '0;
    i_chain     = 1'b0;
    i_out_ready = 1'b0;
    @(negedge clk);
    check("reset_ctrl", 768'({o_frm_ready, o_enc_rst_n, o_enc_en, o_enc_tx_data, o_out_valid, o_err_timeout}),
          768'(6'b100000));
    check("reset_regs", 768'({o_enc_prv_state, o_enc_gen_poly, o_enc_code_rate, o_out_data}), 768'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Rate 1/3 standard polynomials, all-ones frame, no chaining
    run_frame({FRAME_BITS{1'b1}}, CODE_RATE_3, pstd, 1'b0, 0, o1);

    // Rate 1/2 edge-bit frame: low 128 bits must come back zero
    run_frame({1'b1, 126'b0, 1'b1}, CODE_RATE_2, pstd, 1'b0, 0, o1);
    check("rate2_low_zero", 768'(o1[FRAME_BITS-1:0]), 768'(0));

    // Back-to-back chained frames with 20-cycle backpressure on the second
    f1 = {$urandom, $urandom, $urandom, $urandom};
    f2 = {$urandom, $urandom, $urandom, $urandom};
    run_frame(f1, CODE_RATE_3, pstd, 1'b0, 0, o1);
    run_frame(f2, CODE_RATE_3, pstd, 1'b1, 20, o2);
    cont = ref_encode('0, {f1, f2}, 2 * FRAME_BITS, CODE_RATE_3, pstd);
    check("continuous_256", {o1, o2}, cont);

    // Randomized frames; one has a spurious early done from the encoder
    for (int t = 0; t < 5; t++) begin
      stub_mode = (t == 2) ? M_EARLY : M_NORMAL;
      rr = 1'($urandom);
      cr = 1'($urandom);
      pr = gen_poly_t'($urandom);
      run_frame({$urandom, $urandom, $urandom, $urandom}, rr, pr, cr, 0, o1);
    end
    stub_mode = M_NORMAL;

    // Encoder never reports done
    stub_mode = M_NEVER;
    send({$urandom, $urandom, $urandom, $urandom}, CODE_RATE_3, pstd, 1'b1, model_end);
    for (int i = 1; i <= FRAME_BITS + 7; i++) begin
      @(negedge clk);
      if (i == FRAME_BITS + 6) check("no_err_before_timeout", 768'(o_err_timeout), 768'(0));
    end
    check("timeout_state", 768'({o_err_timeout, o_out_valid, o_frm_ready}), 768'(3'b101));
    model_end = '0;
    stub_mode = M_NORMAL;
    run_frame({$urandom, $urandom, $urandom, $urandom}, CODE_RATE_3, pstd, 1'b1, 0, o1);
    check("err_sticky", 768'(o_err_timeout), 768'(1));

    // Reset while streaming bit 60
    f1 = {$urandom, $urandom, $urandom, $urandom};
    send(f1, CODE_RATE_3, pstd, 1'b1, model_end);
    for (int i = 1; i <= 63; i++) @(negedge clk);
    check("run_bit60", 768'({o_enc_en, o_enc_tx_data}), 768'({1'b1, f1[FRAME_BITS-1-60]}));
    rst = 1'b1;
    #1;
    check("midrun_reset_ctrl", 768'({o_frm_ready, o_enc_rst_n, o_enc_en, o_enc_tx_data, o_out_valid, o_err_timeout}),
          768'(6'b100000));
    check("midrun_reset_regs", 768'({o_enc_prv_state, o_enc_gen_poly, o_enc_code_rate, o_out_data}), 768'(0));
    @(negedge clk);
    rst = 1'b0;
    model_end = '0;
    @(negedge clk);
    run_frame({$urandom, $urandom, $urandom, $urandom}, CODE_RATE_2, pstd, 1'b1, 0, o1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog so the bench always terminates
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
